// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, ALU operation encoding and decode helpers
package alu_pkg;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [4:0] {
        ALU_ADD = 5'd0, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
        ALU_MUL = 5'd16, ALU_MULH, ALU_MULHSU, ALU_MULHU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } aluop_t;

    // alt selects SUB/SRA; sub_ok is clear for OP-IMM, where funct7 is immediate bits
    function automatic aluop_t dec_alu(input logic [2:0] f3, input logic alt, input logic sub_ok);
        case (f3)
            3'b000:  return (alt && sub_ok) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic aluop_t dec_mul(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_MUL;
            3'b001:  return ALU_MULH;
            3'b010:  return ALU_MULHSU;
            3'b011:  return ALU_MULHU;
            3'b100:  return ALU_DIV;
            3'b101:  return ALU_DIVU;
            3'b110:  return ALU_REM;
            default: return ALU_REMU;
        endcase
    endfunction
endpackage

// File: rtl/div_iter.sv
// div_iter: unsigned restoring radix-2 divider, one quotient bit per cycle
module div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int CW = $clog2(XLEN) + 1;

    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] dsr;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    assign shifted = {remainder, quotient[XLEN-1]};
    assign diff    = shifted - {1'b0, dsr};
    // high when the current edge completes the final iteration
    assign done    = cnt == CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            dsr       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (start) begin
            cnt       <= CW'(XLEN);
            dsr       <= divisor;
            quotient  <= dividend;
            remainder <= '0;
        end else if (cnt != '0) begin
            cnt       <= cnt - CW'(1);
            remainder <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            quotient  <= {quotient[XLEN-2:0], ~diff[XLEN]};
        end
    end
endmodule

// File: rtl/alu_md_unit.sv
// alu_md_unit: RV32I/M execute unit with registered result over valid/ready
module alu_md_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit EN_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opc,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            cmp_taken,
    output logic            illegal,
    output logic            busy
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [1:0] IDLE = 2'd0, DIV_BUSY = 2'd1, DIV_FIX = 2'd2;

    logic [1:0]        state;
    aluop_t            op;
    logic              is_br, ill_c, cmp_raw, cmp_c;
    logic              accept, is_div, sgn_div, is_rem, div_zero, div_ovf, div_go, div_done;
    logic              neg_q, neg_r, rem_sel;
    logic [XLEN-1:0]   res_raw, res_c, mag_a, mag_b, quo, rem, fix_res;
    logic [2*XLEN-1:0] a_ext, b_ext, prod;
    logic [SHW-1:0]    shamt;

    assign in_ready = state == IDLE && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = state != IDLE;

    always_comb begin
        op    = ALU_ADD;
        ill_c = 1'b0;
        is_br = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE, OPC_SYSTEM: op = ALU_ADD;
            OPC_BRANCH: begin
                is_br = 1'b1;
                ill_c = funct3[2:1] == 2'b01;
            end
            OPC_OP, OPC_OP_IMM: begin
                if (opc == OPC_OP && funct7 == 7'b0000001) begin
                    ill_c = !EN_M;
                    op    = EN_M ? dec_mul(funct3) : ALU_ADD;
                end else if (opc == OPC_OP && funct7 != 7'b0000000 && funct7 != 7'b0100000)
                    ill_c = 1'b1;
                else
                    op = dec_alu(funct3, funct7[5], opc == OPC_OP);
            end
            default: ill_c = 1'b1;
        endcase
    end

    assign shamt = src_b[SHW-1:0];
    // sign-extended operands make one wrapping 2*XLEN multiply serve all four MUL variants
    assign a_ext = {{XLEN{op != ALU_MULHU && src_a[XLEN-1]}}, src_a};
    assign b_ext = {{XLEN{(op == ALU_MUL || op == ALU_MULH) && src_b[XLEN-1]}}, src_b};
    assign prod  = a_ext * b_ext;

    assign is_div   = op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    assign sgn_div  = op == ALU_DIV || op == ALU_REM;
    assign is_rem   = op == ALU_REM || op == ALU_REMU;
    assign div_zero = src_b == '0;
    assign div_ovf  = sgn_div && src_a == {1'b1, {(XLEN-1){1'b0}}} && src_b == '1;
    assign div_go   = accept && is_div && !div_zero && !div_ovf;
    assign mag_a    = (sgn_div && src_a[XLEN-1]) ? -src_a : src_a;
    assign mag_b    = (sgn_div && src_b[XLEN-1]) ? -src_b : src_b;

    always_comb begin
        case (op)
            ALU_ADD:                          res_raw = src_a + src_b;
            ALU_SUB:                          res_raw = src_a - src_b;
            ALU_SLL:                          res_raw = src_a << shamt;
            ALU_SLT:                          res_raw = XLEN'($signed(src_a) < $signed(src_b));
            ALU_SLTU:                         res_raw = XLEN'(src_a < src_b);
            ALU_XOR:                          res_raw = src_a ^ src_b;
            ALU_SRL:                          res_raw = src_a >> shamt;
            ALU_SRA:                          res_raw = $unsigned($signed(src_a) >>> shamt);
            ALU_OR:                           res_raw = src_a | src_b;
            ALU_AND:                          res_raw = src_a & src_b;
            ALU_MUL:                          res_raw = prod[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:  res_raw = prod[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:                res_raw = div_zero ? '1 : src_a;
            ALU_REM, ALU_REMU:                res_raw = div_zero ? src_a : '0;
            default:                          res_raw = '0;
        endcase
    end

    always_comb begin
        case (funct3)
            F3_BEQ:  cmp_raw = src_a == src_b;
            F3_BNE:  cmp_raw = src_a != src_b;
            F3_BLT:  cmp_raw = $signed(src_a) < $signed(src_b);
            F3_BGE:  cmp_raw = $signed(src_a) >= $signed(src_b);
            F3_BLTU: cmp_raw = src_a < src_b;
            F3_BGEU: cmp_raw = src_a >= src_b;
            default: cmp_raw = 1'b0;
        endcase
    end

    assign res_c   = (ill_c || is_br) ? '0 : res_raw;
    assign cmp_c   = is_br && !ill_c && cmp_raw;
    assign fix_res = rem_sel ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);

    div_iter #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_go),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .done      (div_done),
        .quotient  (quo),
        .remainder (rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            cmp_taken <= 1'b0;
            illegal   <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            rem_sel   <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (div_go) begin
                state   <= DIV_BUSY;
                neg_q   <= sgn_div && (src_a[XLEN-1] ^ src_b[XLEN-1]);
                neg_r   <= sgn_div && src_a[XLEN-1];
                rem_sel <= is_rem;
            end else if (accept) begin
                out_valid <= 1'b1;
                result    <= res_c;
                cmp_taken <= cmp_c;
                illegal   <= ill_c;
            end
            if (state == DIV_BUSY && div_done)
                state <= DIV_FIX;
            if (state == DIV_FIX && (!out_valid || out_ready)) begin
                state     <= IDLE;
                out_valid <= 1'b1;
                result    <= fix_res;
                cmp_taken <= 1'b0;
                illegal   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_md_unit.sv
// tb_alu_md_unit: directed scoreboard bench for alu_md_unit (EN_M=1 and EN_M=0)
module tb_alu_md_unit;
    import alu_pkg::*;

    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b1, in_valid2 = 1'b0;
    logic [6:0]  opc = '0, funct7 = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] src_a = '0, src_b = '0;
    logic        in_ready, out_valid, cmp_taken, illegal, busy;
    logic [31:0] result;
    logic        in_ready2, out_valid2, cmp_taken2, illegal2, busy2;
    logic [31:0] result2;

    typedef struct packed {
        logic [31:0] res;
        logic        cmp;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_md_unit #(.XLEN(32), .EN_M(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opc(opc), .funct3(funct3), .funct7(funct7), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .cmp_taken(cmp_taken), .illegal(illegal), .busy(busy)
    );

    alu_md_unit #(.XLEN(32), .EN_M(1'b0)) dut_nom (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .opc(opc), .funct3(funct3), .funct7(funct7), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid2), .out_ready(1'b1), .result(result2),
        .cmp_taken(cmp_taken2), .illegal(illegal2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic run_op(input string tag, input logic [6:0] o, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ec, input logic ei, input int lat);
        int   n;
        exp_t e;
        @(negedge clk);
        opc = o; funct3 = f3; funct7 = f7; src_a = a; src_b = b; in_valid = 1'b1;
        exp_q.push_back({er, ec, ei});
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        if (lat > 1) begin
            chk({tag, " busy"}, 32'(busy), 32'd1);
            chk({tag, " stall"}, 32'(in_ready), 32'd0);
        end
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(lat));
        e = exp_q.pop_front();
        chk({tag, " result"}, result, e.res);
        chk({tag, " cmp"}, 32'(cmp_taken), 32'(e.cmp));
        chk({tag, " illegal"}, 32'(illegal), 32'(e.ill));
        chk({tag, " ready_out"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   spurious;
        repeat (3) @(negedge clk);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst result", result, 32'd0);
        chk("rst cmp", 32'(cmp_taken), 32'd0);
        chk("rst illegal", 32'(illegal), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 32'd1);

        run_op("sub",     OPC_OP,     3'b000, 7'b0100000, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0, 1);
        run_op("addi",    OPC_OP_IMM, 3'b000, 7'b0100000, 32'd5, 32'd7, 32'h0000000C, 1'b0, 1'b0, 1);
        run_op("lui",     OPC_LUI,    3'b000, 7'b0000000, 32'd0, 32'h12345000, 32'h12345000, 1'b0, 1'b0, 1);
        run_op("sra",     OPC_OP,     3'b101, 7'b0100000, 32'h80000000, 32'h24, 32'hF8000000, 1'b0, 1'b0, 1);
        run_op("srl",     OPC_OP,     3'b101, 7'b0000000, 32'h80000000, 32'h24, 32'h08000000, 1'b0, 1'b0, 1);
        run_op("sltu",    OPC_OP,     3'b011, 7'b0000000, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 1);
        run_op("slt",     OPC_OP,     3'b010, 7'b0000000, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 1);
        run_op("bge",     OPC_BRANCH, F3_BGE,  7'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1);
        run_op("bgeu",    OPC_BRANCH, F3_BGEU, 7'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1);
        run_op("blt",     OPC_BRANCH, F3_BLT,  7'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1);
        run_op("br010",   OPC_BRANCH, 3'b010,  7'd0, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1, 1);
        run_op("mulhsu",  OPC_OP, 3'b010, 7'b0000001, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1'b0, 1'b0, 1);
        run_op("mulhu",   OPC_OP, 3'b011, 7'b0000001, 32'hFFFFFFFF, 32'd2, 32'h00000001, 1'b0, 1'b0, 1);
        run_op("mul",     OPC_OP, 3'b000, 7'b0000001, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 1'b0, 1'b0, 1);
        run_op("mulh",    OPC_OP, 3'b001, 7'b0000001, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFF, 1'b0, 1'b0, 1);
        run_op("div",     OPC_OP, 3'b100, 7'b0000001, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 1'b0, 34);
        run_op("rem",     OPC_OP, 3'b110, 7'b0000001, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 1'b0, 34);
        run_op("div_nb",  OPC_OP, 3'b100, 7'b0000001, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0, 34);
        run_op("rem_nb",  OPC_OP, 3'b110, 7'b0000001, 32'd7, 32'hFFFFFFFE, 32'd1, 1'b0, 1'b0, 34);
        run_op("divu",    OPC_OP, 3'b101, 7'b0000001, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 34);
        run_op("remu",    OPC_OP, 3'b111, 7'b0000001, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 34);
        run_op("divu0",   OPC_OP, 3'b101, 7'b0000001, 32'd9, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1);
        run_op("remu0",   OPC_OP, 3'b111, 7'b0000001, 32'd9, 32'd0, 32'd9, 1'b0, 1'b0, 1);
        run_op("rem_ovf", OPC_OP, 3'b110, 7'b0000001, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 1);
        run_op("div_ovf", OPC_OP, 3'b100, 7'b0000001, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 1);
        run_op("bad_opc", 7'b1111111, 3'b000, 7'd0, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 1);
        run_op("bad_f7",  OPC_OP, 3'b000, 7'b0000010, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 1);

        // backpressure: result must hold while the consumer stalls
        @(negedge clk);
        out_ready = 1'b0;
        opc = OPC_OP; funct3 = 3'b000; funct7 = 7'd0; src_a = 32'd1; src_b = 32'd2; in_valid = 1'b1;
        exp_q.push_back({32'd3, 1'b0, 1'b0});
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp out_valid", 32'(out_valid), 32'd1);
        e = exp_q.pop_front();
        repeat (5) begin
            chk("bp result", result, e.res);
            chk("bp in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        chk("bp held", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp drained", 32'(out_valid), 32'd0);

        // reset in the middle of a divide
        opc = OPC_OP; funct3 = 3'b101; funct7 = 7'b0000001; src_a = 32'd100; src_b = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort in_ready", 32'(in_ready), 32'd1);
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        chk("abort no result", 32'(spurious), 32'd0);
        run_op("after_rst", OPC_OP, 3'b100, 7'd0, 32'h0F0F0F0F, 32'hFF00FF00, 32'hF00FF00F, 1'b0, 1'b0, 1);

        // M extension disabled: MUL encoding is illegal
        @(negedge clk);
        opc = OPC_OP; funct3 = 3'b000; funct7 = 7'b0000001; src_a = 32'd3; src_b = 32'd4; in_valid2 = 1'b1;
        chk("nom in_ready", 32'(in_ready2), 32'd1);
        @(negedge clk);
        in_valid2 = 1'b0;
        chk("nom out_valid", 32'(out_valid2), 32'd1);
        chk("nom illegal", 32'(illegal2), 32'd1);
        chk("nom result", result2, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_md_unit.md
Name: alu_md_unit

Overview:
- Parametrised successor to the combinational ALU decoder.
- Decodes opc/funct3/funct7, executes RV32I ALU ops, branch compares and RV32M multiply/divide, and returns a registered result over a valid/ready handshake.
- Sits in the execute stage; the hazard unit stalls issue while in_ready is low.
- Replaces x-valued decode with an explicit illegal flag.

Parameters:
- XLEN, 32, datapath width; power of two, 32 or 64.
- EN_M, 1, enables the M extension; 0 means funct7=0000001 R-type ops are flagged illegal.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit accepts an operation this cycle
- opc  in  7  major opcode
- funct3  in  3  instruction funct3
- funct7  in  7  instruction funct7
- src_a  in  XLEN  operand A (datapath drives 0 for LUI, PC for AUIPC/JAL/JALR)
- src_b  in  XLEN  operand B / immediate
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- result  out  XLEN  ALU/MUL/DIV result; 0 when illegal
- cmp_taken  out  1  branch outcome; 0 for non-branch ops
- illegal  out  1  unsupported opcode/funct combination
- busy  out  1  iterative divide in progress

Behaviour:
- Reset: FSM=IDLE, out_valid=0, result=0, cmp_taken=0, illegal=0, busy=0. Reset aborts any divide in progress and discards the held result.
- Accept: a handshake occurs when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Result hand-off and a new accept may occur in the same cycle (full throughput for 1-cycle ops).
- Decode, ADD group (LUI, AUIPC, JAL, JALR, LOAD, STORE, SYSTEM): ADD.
- Decode, OP/OP-IMM by funct3:
  - 000: OP-IMM or funct7[5]=0 gives ADD; otherwise SUB.
  - 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
  - 101: funct7[5]=0 gives SRL; otherwise SRA.
  - 110: OR. 111: AND.
- Decode, BRANCH: funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
  - cmp_taken = comparison result; result = 0.
  - funct3 010/011 are illegal.
- Decode, OP with funct7=0000001 and EN_M=1, by funct3 000..111: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Illegal: any other opc, or any OP funct7 outside {0000000, 0100000, 0000001}. The result is 0, illegal=1, latency 1.
- Shifts use src_b[$clog2(XLEN)-1:0] only.
- Latency 1 (out_valid the cycle after accept): ALU ops, branches, illegal ops, and all MUL variants. MUL uses a 2·XLEN product; MUL returns low XLEN bits, the MULH variants return high XLEN bits with the specified signedness.
- DIV/REM FSM: IDLE -> DIV_BUSY (XLEN cycles, restoring radix-2, one quotient bit per cycle) -> DIV_FIX (sign correction) -> IDLE.
  - out_valid is asserted XLEN+2 cycles after accept.
  - busy=1 in DIV_BUSY and DIV_FIX.
- Divide special cases resolve at latency 1 with no iteration:
  - Divisor 0: DIV/DIVU return all ones; REM/REMU return the dividend.
  - Signed overflow (MIN/-1): DIV returns MIN; REM returns 0.
- Output hold: result, cmp_taken and illegal are stable while out_valid && !out_ready.
- Divide backpressure: a divide finishing while the previous result is unconsumed waits in DIV_FIX until out_ready.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants (OPC_*);
  - the aluop_t enum, widened from 4 to 5 bits with MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU;
  - the branch funct3 constants.
- Sub-module div_iter, parametrised by XLEN:
  - start/done handshake;
  - unsigned iterative core;
  - sign handling stays in DIV_FIX of alu_md_unit.

Test Plan:
- Basic ops: R-type funct3=000, funct7=0100000, a=5, b=7 -> result=0xFFFFFFFE one cycle after accept. Same with opc=OP-IMM -> 0x0000000C.
- Branch: BGE a=0xFFFFFFFF, b=1 -> cmp_taken=0; BGEU with the same operands -> cmp_taken=1; result=0 in both cases.
- Multiply: MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF; MULHU with the same operands -> 0x00000001; out_valid=1 one cycle after accept in both cases.
- Iterative divide: DIV a=-7, b=2 -> result=0xFFFFFFFD after exactly 34 cycles, in_ready=0 meanwhile. REM with the same operands -> 0xFFFFFFFF.
- Divide special cases: DIVU a=9, b=0 -> 0xFFFFFFFF; REM a=0x80000000, b=0xFFFFFFFF -> 0; both with latency 1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles after a result -> result stable, in_ready=0.
  - rst pulse mid-DIV -> next cycle out_valid=0, busy=0, in_ready=1.
  - EN_M=0 with a MUL encoding -> illegal=1, result=0.
